// File: rtl/order_map_ctrl.sv
// Open-addressed hash-table controller for an order book: ADD / DEL / EXEC on an external
// 2-cycle-latency RAM, linear probing with tombstones and a bounded probe count.
module order_map_ctrl #(
   parameter int ORDER_MAP_DEPTH = 1024,
   parameter int MAX_PROBES      = 8
) (
   input  logic                                 clkIn,
   input  logic                                 rstNIn,
   input  logic                                 reqValidIn,
   output logic                                 reqReadyOut,
   input  logic [1:0]                           reqOpIn,
   input  logic [63:0]                          refNumIn,
   input  logic [15:0]                          locateIn,
   input  logic [31:0]                          priceIn,
   input  logic [31:0]                          sharesIn,
   input  logic                                 buySellIn,
   output logic [$clog2(ORDER_MAP_DEPTH)-1:0]   ramAddrOut,
   output logic                                 ramWrEnOut,
   output logic [63:0]                          ramWrRefOut,
   output logic [80:0]                          ramWrDataOut,
   input  logic [63:0]                          ramRdRefIn,
   input  logic [80:0]                          ramRdDataIn,
   output logic                                 rspValidOut,
   output logic [1:0]                           rspOpOut,
   output logic [1:0]                           rspStatusOut,
   output logic [15:0]                          rspLocateOut,
   output logic [31:0]                          rspPriceOut,
   output logic [31:0]                          rspSharesOut,
   output logic                                 rspBuySellOut
);

   localparam int ADDR_BITS = $clog2(ORDER_MAP_DEPTH);
   localparam int CNT_BITS  = $clog2(MAX_PROBES + 1);

   localparam logic [1:0]  OP_ADD  = 2'b00;
   localparam logic [1:0]  OP_DEL  = 2'b01;
   localparam logic [1:0]  OP_RSV  = 2'b11;
   localparam logic [1:0]  ST_OK   = 2'b00;
   localparam logic [1:0]  ST_NF   = 2'b01;
   localparam logic [1:0]  ST_FULL = 2'b10;
   localparam logic [1:0]  ST_BAD  = 2'b11;
   localparam logic [63:0] REF_TOMB = '1;

   typedef enum logic [2:0] {IDLE, RD_WAIT, CHECK, WRITE, RESP} stateT;

   stateT                 stateQ, stateD;
   logic                  readyEnQ;
   logic                  waitQ, waitD;
   logic [ADDR_BITS-1:0]  addrQ, addrD;
   logic [CNT_BITS-1:0]   probeQ, probeD;
   logic [1:0]            opQ, opD;
   logic [63:0]           refQ, refD;
   logic [15:0]           locQ, locD;
   logic [31:0]           priceQ, priceD;
   logic [31:0]           sharesQ, sharesD;
   logic                  sideQ, sideD;
   logic [1:0]            statusQ, statusD;
   logic [15:0]           rspLocQ, rspLocD;
   logic [31:0]           rspPriceQ, rspPriceD;
   logic [31:0]           rspSharesQ, rspSharesD;
   logic                  rspSideQ, rspSideD;
   logic [63:0]           wrRefQ, wrRefD;
   logic [80:0]           wrDataQ, wrDataD;

   logic                  accept;
   logic                  slotEmpty, slotTomb, slotHit, probeMiss;
   logic [31:0]           storedShares;
   logic [CNT_BITS-1:0]   probeNext;

   function automatic logic [ADDR_BITS-1:0] hashRef(input logic [63:0] r);
      return r[ADDR_BITS-1:0] ^ r[2*ADDR_BITS-1:ADDR_BITS] ^
             r[3*ADDR_BITS-1:2*ADDR_BITS] ^ r[4*ADDR_BITS-1:3*ADDR_BITS];
   endfunction

   assign accept       = reqValidIn && reqReadyOut;
   assign slotEmpty    = (ramRdRefIn == 64'd0);
   assign slotTomb     = (ramRdRefIn == REF_TOMB);
   assign slotHit      = (ramRdRefIn == refQ);
   assign storedShares = ramRdDataIn[32:1];
   assign probeNext    = probeQ + CNT_BITS'(1);

   // Next-state logic; every register holds unless a state below says otherwise.
   always_comb begin
      stateD     = stateQ;
      waitD      = waitQ;
      addrD      = addrQ;
      probeD     = probeQ;
      opD        = opQ;
      refD       = refQ;
      locD       = locQ;
      priceD     = priceQ;
      sharesD    = sharesQ;
      sideD      = sideQ;
      statusD    = statusQ;
      rspLocD    = rspLocQ;
      rspPriceD  = rspPriceQ;
      rspSharesD = rspSharesQ;
      rspSideD   = rspSideQ;
      wrRefD     = wrRefQ;
      wrDataD    = wrDataQ;
      probeMiss  = 1'b0;

      case (stateQ)
         IDLE: begin
            if (accept) begin
               opD        = reqOpIn;
               refD       = refNumIn;
               locD       = locateIn;
               priceD     = priceIn;
               sharesD    = sharesIn;
               sideD      = buySellIn;
               statusD    = ST_OK;
               rspLocD    = '0;
               rspPriceD  = '0;
               rspSharesD = '0;
               rspSideD   = 1'b0;
               probeD     = '0;
               waitD      = 1'b0;
               // Reserved op and the two sentinel refs can never be stored, so reject up front.
               if (reqOpIn == OP_RSV || refNumIn == 64'd0 || refNumIn == REF_TOMB) begin
                  statusD = ST_BAD;
                  stateD  = RESP;
               end else begin
                  addrD  = hashRef(refNumIn);
                  stateD = RD_WAIT;
               end
            end
         end
         RD_WAIT: begin
            if (waitQ) begin
               stateD = CHECK;
            end else begin
               waitD = 1'b1;
            end
         end
         CHECK: begin
            case (opQ)
               OP_ADD: begin
                  if (slotEmpty || slotTomb) begin
                     wrRefD  = refQ;
                     wrDataD = {locQ, priceQ, sharesQ, sideQ};
                     stateD  = WRITE;
                  end else begin
                     probeMiss = 1'b1;
                  end
               end
               OP_DEL: begin
                  if (slotHit) begin
                     wrRefD     = REF_TOMB;
                     wrDataD    = ramRdDataIn;
                     rspLocD    = ramRdDataIn[80:65];
                     rspPriceD  = ramRdDataIn[64:33];
                     rspSharesD = storedShares;
                     rspSideD   = ramRdDataIn[0];
                     stateD     = WRITE;
                  end else if (slotEmpty) begin
                     statusD = ST_NF;
                     stateD  = RESP;
                  end else begin
                     probeMiss = 1'b1;
                  end
               end
               default: begin
                  if (slotHit) begin
                     rspLocD   = ramRdDataIn[80:65];
                     rspPriceD = ramRdDataIn[64:33];
                     rspSideD  = ramRdDataIn[0];
                     // A fill that covers the whole resting size retires the order.
                     if (sharesQ >= storedShares) begin
                        wrRefD     = REF_TOMB;
                        wrDataD    = ramRdDataIn;
                        rspSharesD = storedShares;
                     end else begin
                        wrRefD     = refQ;
                        wrDataD    = {ramRdDataIn[80:33], storedShares - sharesQ, ramRdDataIn[0]};
                        rspSharesD = sharesQ;
                     end
                     stateD = WRITE;
                  end else if (slotEmpty) begin
                     statusD = ST_NF;
                     stateD  = RESP;
                  end else begin
                     probeMiss = 1'b1;
                  end
               end
            endcase

            if (probeMiss) begin
               probeD = probeNext;
               if (probeNext == CNT_BITS'(MAX_PROBES)) begin
                  statusD = (opQ == OP_ADD) ? ST_FULL : ST_NF;
                  stateD  = RESP;
               end else begin
                  addrD  = addrQ + ADDR_BITS'(1);
                  waitD  = 1'b0;
                  stateD = RD_WAIT;
               end
            end
         end
         WRITE:   stateD = RESP;
         RESP:    stateD = IDLE;
         default: stateD = IDLE;
      endcase
   end

   // State and datapath registers; reset abandons any request in flight.
   always_ff @(posedge clkIn or negedge rstNIn) begin
      if (!rstNIn) begin
         stateQ     <= IDLE;
         readyEnQ   <= 1'b0;
         waitQ      <= 1'b0;
         addrQ      <= '0;
         probeQ     <= '0;
         opQ        <= '0;
         refQ       <= '0;
         locQ       <= '0;
         priceQ     <= '0;
         sharesQ    <= '0;
         sideQ      <= 1'b0;
         statusQ    <= '0;
         rspLocQ    <= '0;
         rspPriceQ  <= '0;
         rspSharesQ <= '0;
         rspSideQ   <= 1'b0;
         wrRefQ     <= '0;
         wrDataQ    <= '0;
      end else begin
         stateQ     <= stateD;
         readyEnQ   <= 1'b1;
         waitQ      <= waitD;
         addrQ      <= addrD;
         probeQ     <= probeD;
         opQ        <= opD;
         refQ       <= refD;
         locQ       <= locD;
         priceQ     <= priceD;
         sharesQ    <= sharesD;
         sideQ      <= sideD;
         statusQ    <= statusD;
         rspLocQ    <= rspLocD;
         rspPriceQ  <= rspPriceD;
         rspSharesQ <= rspSharesD;
         rspSideQ   <= rspSideD;
         wrRefQ     <= wrRefD;
         wrDataQ    <= wrDataD;
      end
   end

   assign reqReadyOut   = readyEnQ && (stateQ == IDLE);
   assign ramAddrOut    = addrQ;
   assign ramWrEnOut    = (stateQ == WRITE);
   assign ramWrRefOut   = wrRefQ;
   assign ramWrDataOut  = wrDataQ;
   assign rspValidOut   = (stateQ == RESP);
   assign rspOpOut      = rspValidOut ? opQ        : 2'b00;
   assign rspStatusOut  = rspValidOut ? statusQ    : 2'b00;
   assign rspLocateOut  = rspValidOut ? rspLocQ    : 16'd0;
   assign rspPriceOut   = rspValidOut ? rspPriceQ  : 32'd0;
   assign rspSharesOut  = rspValidOut ? rspSharesQ : 32'd0;
   assign rspBuySellOut = rspValidOut ? rspSideQ   : 1'b0;

endmodule

// File: tb/tb_order_map_ctrl.sv
// Bench for order_map_ctrl: a 2-cycle-latency RAM model plus an independent hash-table
// reference model that predicts status, latency, write slot/contents and response fields.
module tb_order_map_ctrl;

   localparam int DEPTH = 16;
   localparam int MAXP  = 2;
   localparam int ABITS = $clog2(DEPTH);

   localparam logic [1:0]  OP_ADD  = 2'b00;
   localparam logic [1:0]  OP_DEL  = 2'b01;
   localparam logic [1:0]  OP_EXEC = 2'b10;
   localparam logic [1:0]  OP_RSV  = 2'b11;
   localparam logic [1:0]  ST_OK   = 2'b00;
   localparam logic [1:0]  ST_NF   = 2'b01;
   localparam logic [1:0]  ST_FULL = 2'b10;
   localparam logic [1:0]  ST_BAD  = 2'b11;
   localparam logic [63:0] ALL1    = '1;

   logic             clkIn = 1'b0;
   logic             rstNIn = 1'b0;
   logic             reqValidIn = 1'b0;
   logic             reqReadyOut;
   logic [1:0]       reqOpIn = '0;
   logic [63:0]      refNumIn = '0;
   logic [15:0]      locateIn = '0;
   logic [31:0]      priceIn = '0;
   logic [31:0]      sharesIn = '0;
   logic             buySellIn = 1'b0;
   logic [ABITS-1:0] ramAddrOut;
   logic             ramWrEnOut;
   logic [63:0]      ramWrRefOut;
   logic [80:0]      ramWrDataOut;
   logic [63:0]      ramRdRefIn;
   logic [80:0]      ramRdDataIn;
   logic             rspValidOut;
   logic [1:0]       rspOpOut;
   logic [1:0]       rspStatusOut;
   logic [15:0]      rspLocateOut;
   logic [31:0]      rspPriceOut;
   logic [31:0]      rspSharesOut;
   logic             rspBuySellOut;

   int vectors = 0;
   int miscompares = 0;
   int wrPulses = 0;
   int rspPulses = 0;
   int lastRspCyc, lastWrCyc, lastWrAddr;
   logic [1:0]  lastStatus;
   logic [31:0] lastShares;

   // RAM seen by the DUT: written only by the DUT, read data trails the address by two edges.
   logic [63:0]      ramRef  [DEPTH] = '{default: '0};
   logic [80:0]      ramData [DEPTH] = '{default: '0};
   logic [ABITS-1:0] addrD1 = '0;
   logic [ABITS-1:0] addrD2 = '0;

   // Reference model contents, updated only from the model's own predictions.
   logic [63:0] mRef    [DEPTH] = '{default: '0};
   logic [15:0] mLoc    [DEPTH] = '{default: '0};
   logic [31:0] mPrice  [DEPTH] = '{default: '0};
   logic [31:0] mShares [DEPTH] = '{default: '0};
   logic        mSide   [DEPTH] = '{default: 1'b0};

   order_map_ctrl #(.ORDER_MAP_DEPTH(DEPTH), .MAX_PROBES(MAXP)) dut (
      .clkIn(clkIn), .rstNIn(rstNIn),
      .reqValidIn(reqValidIn), .reqReadyOut(reqReadyOut), .reqOpIn(reqOpIn),
      .refNumIn(refNumIn), .locateIn(locateIn), .priceIn(priceIn),
      .sharesIn(sharesIn), .buySellIn(buySellIn),
      .ramAddrOut(ramAddrOut), .ramWrEnOut(ramWrEnOut), .ramWrRefOut(ramWrRefOut),
      .ramWrDataOut(ramWrDataOut), .ramRdRefIn(ramRdRefIn), .ramRdDataIn(ramRdDataIn),
      .rspValidOut(rspValidOut), .rspOpOut(rspOpOut), .rspStatusOut(rspStatusOut),
      .rspLocateOut(rspLocateOut), .rspPriceOut(rspPriceOut),
      .rspSharesOut(rspSharesOut), .rspBuySellOut(rspBuySellOut)
   );

   always #5 clkIn = ~clkIn;

   always_ff @(posedge clkIn) begin
      if (ramWrEnOut) begin
         ramRef[ramAddrOut]  <= ramWrRefOut;
         ramData[ramAddrOut] <= ramWrDataOut;
      end
      addrD1 <= ramAddrOut;
      addrD2 <= addrD1;
   end

   assign ramRdRefIn  = ramRef[addrD2];
   assign ramRdDataIn = ramData[addrD2];

   // Pulse counters used to prove that an abandoned request leaves no trace.
   always @(posedge clkIn) begin
      if (ramWrEnOut)  wrPulses  = wrPulses + 1;
      if (rspValidOut) rspPulses = rspPulses + 1;
   end

   function automatic int modelHash(input logic [63:0] r);
      logic [63:0] v;
      int h;
      v = r;
      h = 0;
      for (int i = 0; i < 4; i++) begin
         h = h ^ int'(v % 64'(DEPTH));
         v = v / 64'(DEPTH);
      end
      return h;
   endfunction

   task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Predict the outcome from the model, run one request, compare everything observed.
   task automatic applyStimulus(input logic [1:0] op, input logic [63:0] refNum,
                                input logic [15:0] loc, input logic [31:0] price,
                                input logic [31:0] shares, input logic side);
      int         slot, expLat, expAddr, wrCount, wrCyc, wrAddr, rspCyc;
      bit         done, expWrite, readyBusy;
      logic [1:0] expStatus, obsStatus, obsOp;
      logic [63:0] expWrRef, wrRef;
      logic [80:0] wrData;
      logic [15:0] nLoc, rLoc, oLoc;
      logic [31:0] nPrice, nShares, rPrice, rShares, oPrice, oShares;
      logic        nSide, rSide, oSide;

      done = 0; expWrite = 0; expAddr = 0; expWrRef = '0;
      nLoc = '0; nPrice = '0; nShares = '0; nSide = 1'b0;
      rLoc = '0; rPrice = '0; rShares = '0; rSide = 1'b0;
      expLat = 1 + 3 * MAXP;
      expStatus = (op == OP_ADD) ? ST_FULL : ST_NF;
      if (op == OP_RSV || refNum == 64'd0 || refNum == ALL1) begin
         expStatus = ST_BAD;
         expLat = 1;
      end else begin
         for (int p = 0; p < MAXP && !done; p++) begin
            slot = (modelHash(refNum) + p) % DEPTH;
            if (op == OP_ADD) begin
               if (mRef[slot] == 64'd0 || mRef[slot] == ALL1) begin
                  done = 1; expWrite = 1; expAddr = slot; expStatus = ST_OK;
                  expLat = 3 * (p + 1) + 2; expWrRef = refNum;
                  nLoc = loc; nPrice = price; nShares = shares; nSide = side;
               end
            end else if (mRef[slot] == refNum) begin
               done = 1; expWrite = 1; expAddr = slot; expStatus = ST_OK;
               expLat = 3 * (p + 1) + 2;
               rLoc = mLoc[slot]; rPrice = mPrice[slot]; rSide = mSide[slot];
               nLoc = mLoc[slot]; nPrice = mPrice[slot]; nSide = mSide[slot];
               if (op == OP_DEL || shares >= mShares[slot]) begin
                  expWrRef = ALL1; nShares = mShares[slot]; rShares = mShares[slot];
               end else begin
                  expWrRef = refNum; nShares = mShares[slot] - shares; rShares = shares;
               end
            end else if (mRef[slot] == 64'd0) begin
               done = 1; expStatus = ST_NF; expLat = 3 * (p + 1) + 1;
            end
         end
      end

      @(negedge clkIn);
      checkOutput("ready_idle", 128'(reqReadyOut), 128'(1'b1));
      reqValidIn = 1'b1; reqOpIn = op; refNumIn = refNum;
      locateIn = loc; priceIn = price; sharesIn = shares; buySellIn = side;
      wrCount = 0; wrCyc = 0; wrAddr = 0; wrRef = '0; wrData = '0; rspCyc = 0;
      readyBusy = 0; obsStatus = '0; obsOp = '0;
      oLoc = '0; oPrice = '0; oShares = '0; oSide = 1'b0;
      @(posedge clkIn);
      for (int c = 1; c <= 40; c++) begin
         #1;
         reqValidIn = 1'b0;
         if (reqReadyOut) readyBusy = 1;
         if (ramWrEnOut) begin
            wrCount++; wrCyc = c; wrAddr = int'(ramAddrOut);
            wrRef = ramWrRefOut; wrData = ramWrDataOut;
         end
         if (rspValidOut) begin
            rspCyc = c; obsStatus = rspStatusOut; obsOp = rspOpOut;
            oLoc = rspLocateOut; oPrice = rspPriceOut;
            oShares = rspSharesOut; oSide = rspBuySellOut;
            break;
         end
         @(posedge clkIn);
      end

      checkOutput("latency", 128'(rspCyc), 128'(expLat));
      checkOutput("rsp_status", 128'(obsStatus), 128'(expStatus));
      checkOutput("rsp_op", 128'(obsOp), 128'(op));
      checkOutput("rsp_locate", 128'(oLoc), 128'(rLoc));
      checkOutput("rsp_price", 128'(oPrice), 128'(rPrice));
      checkOutput("rsp_shares", 128'(oShares), 128'(rShares));
      checkOutput("rsp_side", 128'(oSide), 128'(rSide));
      checkOutput("busy_ready", 128'(readyBusy), 128'(1'b0));
      checkOutput("write_count", 128'(wrCount), 128'(expWrite));
      if (expWrite) begin
         checkOutput("write_cycle", 128'(wrCyc), 128'(expLat - 1));
         checkOutput("write_addr", 128'(wrAddr), 128'(expAddr));
         checkOutput("write_ref", 128'(wrRef), 128'(expWrRef));
         checkOutput("write_data", 128'(wrData), 128'({nLoc, nPrice, nShares, nSide}));
         mRef[expAddr] = expWrRef; mLoc[expAddr] = nLoc; mPrice[expAddr] = nPrice;
         mShares[expAddr] = nShares; mSide[expAddr] = nSide;
      end
      lastRspCyc = rspCyc; lastWrCyc = wrCyc; lastWrAddr = wrAddr;
      lastStatus = obsStatus; lastShares = oShares;

      @(posedge clkIn); #1;
      checkOutput("ready_after_rsp", 128'(reqReadyOut), 128'(1'b1));
   endtask

   // Directed scenarios first, then a randomized mix over a small pool of refs.
   initial begin
      logic [63:0] pool [8];
      logic [63:0] refv;
      logic [1:0]  opv;
      int          r, wrBefore, rspBefore;

      repeat (3) @(posedge clkIn);
      #1;
      checkOutput("reset_ready", 128'(reqReadyOut), 128'(1'b0));
      checkOutput("reset_wren", 128'(ramWrEnOut), 128'(1'b0));
      checkOutput("reset_rspvalid", 128'(rspValidOut), 128'(1'b0));
      checkOutput("reset_addr", 128'(ramAddrOut), 128'(0));
      @(negedge clkIn);
      rstNIn = 1'b1;
      #1;
      checkOutput("ready_before_edge", 128'(reqReadyOut), 128'(1'b0));
      @(posedge clkIn); #1;
      checkOutput("ready_first_edge", 128'(reqReadyOut), 128'(1'b1));

      applyStimulus(OP_ADD, 64'h1234, 16'h00AB, 32'd5000, 32'd100, 1'b1);
      checkOutput("add_first_lat", 128'(lastRspCyc), 128'(5));
      checkOutput("add_first_wrcyc", 128'(lastWrCyc), 128'(4));
      checkOutput("add_first_addr", 128'(lastWrAddr), 128'(4));
      applyStimulus(OP_EXEC, 64'h1234, 16'h0, 32'd0, 32'd40, 1'b0);
      checkOutput("exec_partial_shares", 128'(lastShares), 128'(40));
      applyStimulus(OP_EXEC, 64'h1234, 16'h0, 32'd0, 32'd80, 1'b0);
      checkOutput("exec_full_shares", 128'(lastShares), 128'(60));

      applyStimulus(OP_ADD, 64'h0008, 16'h0011, 32'd100, 32'd7, 1'b0);
      applyStimulus(OP_ADD, 64'h0019, 16'h0022, 32'd200, 32'd9, 1'b1);
      checkOutput("collide_addr", 128'(lastWrAddr), 128'(9));
      applyStimulus(OP_DEL, 64'h0019, 16'h0, 32'd0, 32'd0, 1'b0);
      checkOutput("del_probe2_lat", 128'(lastRspCyc), 128'(8));

      applyStimulus(OP_ADD, 64'h000F, 16'h0033, 32'd300, 32'd3, 1'b0);
      applyStimulus(OP_ADD, 64'h001E, 16'h0044, 32'd400, 32'd4, 1'b1);
      checkOutput("wrap_addr", 128'(lastWrAddr), 128'(0));

      applyStimulus(OP_ADD, 64'h0002, 16'h0055, 32'd500, 32'd5, 1'b0);
      applyStimulus(OP_ADD, 64'h0013, 16'h0066, 32'd600, 32'd6, 1'b1);
      applyStimulus(OP_ADD, 64'h0020, 16'h0077, 32'd700, 32'd8, 1'b0);
      checkOutput("full_status", 128'(lastStatus), 128'(ST_FULL));
      applyStimulus(OP_DEL, 64'h0004, 16'h0, 32'd0, 32'd0, 1'b0);
      checkOutput("absent_status", 128'(lastStatus), 128'(ST_NF));
      checkOutput("absent_lat", 128'(lastRspCyc), 128'(7));

      @(negedge clkIn);
      reqValidIn = 1'b1; reqOpIn = OP_ADD; refNumIn = 64'h0777;
      locateIn = 16'h0099; priceIn = 32'd900; sharesIn = 32'd9; buySellIn = 1'b1;
      @(posedge clkIn); #1;
      reqValidIn = 1'b0;
      wrBefore = wrPulses; rspBefore = rspPulses;
      #2;
      rstNIn = 1'b0;
      #1;
      checkOutput("midrst_ready", 128'(reqReadyOut), 128'(1'b0));
      checkOutput("midrst_wren", 128'(ramWrEnOut), 128'(1'b0));
      checkOutput("midrst_addr", 128'(ramAddrOut), 128'(0));
      checkOutput("midrst_wrref", 128'(ramWrRefOut), 128'(0));
      repeat (2) @(posedge clkIn);
      @(negedge clkIn);
      rstNIn = 1'b1;
      #1;
      checkOutput("midrst_ready_low", 128'(reqReadyOut), 128'(1'b0));
      @(posedge clkIn); #1;
      checkOutput("midrst_ready_high", 128'(reqReadyOut), 128'(1'b1));
      repeat (6) @(posedge clkIn);
      #1;
      checkOutput("midrst_no_write", 128'(wrPulses), 128'(wrBefore));
      checkOutput("midrst_no_rsp", 128'(rspPulses), 128'(rspBefore));
      applyStimulus(OP_ADD, 64'd0, 16'h0, 32'd0, 32'd0, 1'b0);
      checkOutput("badreq_lat", 128'(lastRspCyc), 128'(1));
      checkOutput("badreq_status", 128'(lastStatus), 128'(ST_BAD));

      for (int i = 0; i < 8; i++) begin
         pool[i] = {1'b0, 31'($urandom), 32'($urandom)} | 64'd1;
      end
      for (int n = 0; n < 80; n++) begin
         refv = pool[$urandom_range(0, 7)];
         r = int'($urandom_range(0, 19));
         if (r == 0) refv = 64'd0;
         if (r == 1) refv = ALL1;
         r = int'($urandom_range(0, 99));
         opv = (r < 45) ? OP_ADD : (r < 70) ? OP_DEL : (r < 95) ? OP_EXEC : OP_RSV;
         applyStimulus(opv, refv, 16'($urandom), $urandom,
                       (opv == OP_ADD) ? 32'($urandom_range(1, 100)) : 32'($urandom_range(0, 120)),
                       1'($urandom));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
